// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, ALU and
// extender codes, and the opcode/funct values of the supported instruction set.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_TRAP = 3'd7
  } state_t;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_LUI = 5'd7;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;

endpackage

// File: rtl/mc_decode.sv
// Combinational decode of opcode/funct into instruction class flags, ALU
// operation, extender mode, operand selects and a legal-instruction flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       is_alu,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_link,
  output logic       reg_dst,
  output logic       alu_src,
  output logic [1:0] ext_op,
  output logic [4:0] alu_ctr,
  output logic       legal
);

  always_comb begin
    is_alu    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_link   = 1'b0;
    reg_dst   = 1'b0;
    alu_src   = 1'b0;
    ext_op    = EXT_ZERO;
    alu_ctr   = ALU_ADD;
    legal     = 1'b1;
    case (op)
      OP_R: begin
        is_alu  = 1'b1;
        reg_dst = 1'b1;
        case (funct)
          FN_ADDU: alu_ctr = ALU_ADD;
          FN_SUBU: alu_ctr = ALU_SUB;
          FN_AND:  alu_ctr = ALU_AND;
          FN_OR:   alu_ctr = ALU_OR;
          FN_SLT:  alu_ctr = ALU_SLT;
          FN_SLL:  alu_ctr = ALU_SLL;
          FN_SRL:  alu_ctr = ALU_SRL;
          FN_JR: begin
            is_alu  = 1'b0;
            reg_dst = 1'b0;
            is_jump = 1'b1;
          end
          default: begin
            is_alu  = 1'b0;
            reg_dst = 1'b0;
            legal   = 1'b0;
          end
        endcase
      end
      OP_ADDIU: begin
        is_alu  = 1'b1;
        alu_src = 1'b1;
        ext_op  = EXT_SIGN;
        alu_ctr = ALU_ADD;
      end
      OP_ORI: begin
        is_alu  = 1'b1;
        alu_src = 1'b1;
        ext_op  = EXT_ZERO;
        alu_ctr = ALU_OR;
      end
      OP_LUI: begin
        is_alu  = 1'b1;
        alu_src = 1'b1;
        ext_op  = EXT_UPPER;
        alu_ctr = ALU_LUI;
      end
      OP_LW: begin
        is_load = 1'b1;
        alu_src = 1'b1;
        ext_op  = EXT_SIGN;
        alu_ctr = ALU_ADD;
      end
      OP_SW: begin
        is_store = 1'b1;
        alu_src  = 1'b1;
        ext_op   = EXT_SIGN;
        alu_ctr  = ALU_ADD;
      end
      // beq and bne share SUB; the NPC combines zero with the opcode
      OP_BEQ, OP_BNE: begin
        is_branch = 1'b1;
        ext_op    = EXT_SIGN;
        alu_ctr   = ALU_SUB;
      end
      OP_J: is_jump = 1'b1;
      OP_JAL: begin
        is_jump = 1'b1;
        is_link = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB controller for the MIPS datapath with memory
// wait states, a MEM timeout trap and a retired-instruction counter.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RegDst,
  output logic             RegWr,
  output logic             ALUSrc,
  output logic             MemWr,
  output logic             MemtoReg,
  output logic [1:0]       ExtOp,
  output logic [4:0]       ALUctr,
  output logic             Branch,
  output logic             Jump,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TIMEOUT_ON = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t             state_q;
  logic [CNT_W-1:0]   retired_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               illegal_q;
  logic               bus_err_q;
  logic [5:0]         ir_op;
  logic [5:0]         ir_fn;

  logic is_alu, is_load, is_store, is_branch, is_jump, is_link;
  logic dec_reg_dst, dec_alu_src, legal;
  logic [1:0] dec_ext_op;
  logic [4:0] dec_alu_ctr;

  logic pc_wr, ir_wr, reg_wr, mem_wr;

  // Only opcode and funct steer the controller; the NPC alone consumes zero
  logic unused_inputs;
  assign unused_inputs = ^{instruction[25:6], zero};

  // Controller's own copy of the IR fields, loaded alongside the datapath IR
  always_ff @(posedge clk) begin
    if (state_q == ST_IF) begin
      ir_op <= instruction[31:26];
      ir_fn <= instruction[5:0];
    end
  end

  mc_decode u_decode (
    .op        (ir_op),
    .funct     (ir_fn),
    .is_alu    (is_alu),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .is_link   (is_link),
    .reg_dst   (dec_reg_dst),
    .alu_src   (dec_alu_src),
    .ext_op    (dec_ext_op),
    .alu_ctr   (dec_alu_ctr),
    .legal     (legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IF;
      retired_q <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (pc_wr)
        retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        ST_IF: state_q <= ST_ID;
        ST_ID: begin
          if (!legal) begin
            state_q   <= ST_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q <= ST_EX;
          end
        end
        ST_EX: begin
          if (is_load || is_store)
            state_q <= ST_MEM;
          else if (is_alu)
            state_q <= ST_WB;
          else
            state_q <= ST_IF;
        end
        ST_MEM: begin
          if (mem_rdy) begin
            wait_cnt <= '0;
            state_q  <= is_load ? ST_WB : ST_IF;
          end else if (TIMEOUT_ON && wait_cnt == WAIT_LAST) begin
            wait_cnt  <= '0;
            state_q   <= ST_TRAP;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_WB:   state_q <= ST_IF;
        default: state_q <= ST_TRAP;
      endcase
    end
  end

  // ALU controls stay valid from EX through WB so the address/result is stable
  always_comb begin
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    reg_wr   = 1'b0;
    mem_wr   = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    ExtOp    = EXT_ZERO;
    ALUctr   = ALU_ADD;
    Branch   = 1'b0;
    Jump     = 1'b0;
    case (state_q)
      ST_IF: ir_wr = 1'b1;
      ST_EX: begin
        ALUSrc = dec_alu_src;
        ExtOp  = dec_ext_op;
        ALUctr = dec_alu_ctr;
        if (is_branch || is_jump) begin
          pc_wr  = 1'b1;
          Branch = is_branch;
          Jump   = is_jump;
          reg_wr = is_link;
        end
      end
      ST_MEM: begin
        ALUSrc = dec_alu_src;
        ExtOp  = dec_ext_op;
        ALUctr = dec_alu_ctr;
        mem_wr = is_store;
        pc_wr  = is_store && mem_rdy;
      end
      ST_WB: begin
        ALUSrc   = dec_alu_src;
        ExtOp    = dec_ext_op;
        ALUctr   = dec_alu_ctr;
        RegDst   = dec_reg_dst;
        MemtoReg = is_load;
        reg_wr   = 1'b1;
        pc_wr    = 1'b1;
      end
      default: ;
    endcase
  end

  // Gate enables with reset so an in-flight write dies the moment reset rises
  assign PCWr  = pc_wr  && !reset;
  assign IRWr  = ir_wr  && !reset;
  assign RegWr = reg_wr && !reset;
  assign MemWr = mem_wr && !reset;

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control vectors are queued
// as instructions are issued and compared against the DUT cycle by cycle.
module tb_mc_ctrl;

  localparam int CNT_W = 32;
  localparam int TMO   = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      instruction;
  logic             zero;
  logic             mem_rdy;
  logic             PCWr, IRWr, RegDst, RegWr, ALUSrc, MemWr, MemtoReg;
  logic [1:0]       ExtOp;
  logic [4:0]       ALUctr;
  logic             Branch, Jump, illegal, bus_err;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
    .mem_rdy(mem_rdy), .PCWr(PCWr), .IRWr(IRWr), .RegDst(RegDst),
    .RegWr(RegWr), .ALUSrc(ALUSrc), .MemWr(MemWr), .MemtoReg(MemtoReg),
    .ExtOp(ExtOp), .ALUctr(ALUctr), .Branch(Branch), .Jump(Jump),
    .illegal(illegal), .bus_err(bus_err), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr, irwr, regwr, memwr, regdst, memtoreg, branch, jump, alusrc;
    logic [1:0] extop;
    logic [4:0] aluctr;
    logic       ill, berr;
  } ctl_t;

  typedef struct {
    ctl_t        ctl;
    logic [31:0] ret;
    logic        rdy;
    logic [31:0] ins;
  } exp_t;

  ctl_t obs;
  assign obs = {state, PCWr, IRWr, RegWr, MemWr, RegDst, MemtoReg, Branch, Jump,
                ALUSrc, ExtOp, ALUctr, illegal, bus_err};

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] exp_ret;
  logic        exp_ill, exp_berr;

  function automatic ctl_t base(input logic [2:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  // Reference table: class 0 alu, 1 lw, 2 sw, 3 beq/bne, 4 j, 5 jal, 6 jr, 7 illegal
  function automatic int classify(input logic [31:0] ins, output logic [4:0] a,
                                  output logic [1:0] e, output logic s, output logic d);
    int cls;
    a = 5'd0; e = 2'd0; s = 1'b0; d = 1'b0; cls = 7;
    case (ins[31:26])
      6'h00: begin
        cls = 0; d = 1'b1;
        case (ins[5:0])
          6'h21: a = 5'd0;
          6'h23: a = 5'd1;
          6'h24: a = 5'd2;
          6'h25: a = 5'd3;
          6'h2A: a = 5'd4;
          6'h00: a = 5'd5;
          6'h02: a = 5'd6;
          6'h08: begin cls = 6; d = 1'b0; end
          default: begin cls = 7; d = 1'b0; end
        endcase
      end
      6'h09: begin cls = 0; a = 5'd0; e = 2'd1; s = 1'b1; end
      6'h0D: begin cls = 0; a = 5'd3; e = 2'd0; s = 1'b1; end
      6'h0F: begin cls = 0; a = 5'd7; e = 2'd2; s = 1'b1; end
      6'h23: begin cls = 1; a = 5'd0; e = 2'd1; s = 1'b1; end
      6'h2B: begin cls = 2; a = 5'd0; e = 2'd1; s = 1'b1; end
      6'h04, 6'h05: begin cls = 3; a = 5'd1; e = 2'd1; end
      6'h02: cls = 4;
      6'h03: cls = 5;
      default: cls = 7;
    endcase
    return cls;
  endfunction

  task automatic push(input ctl_t c, input logic rdy, input logic [31:0] ins);
    exp_t x;
    x.ctl      = c;
    x.ctl.ill  = exp_ill;
    x.ctl.berr = exp_berr;
    x.ret      = exp_ret;
    x.rdy      = rdy;
    x.ins      = ins;
    sbq.push_back(x);
  endtask

  // waits = cycles with mem_rdy low in MEM; waits >= TMO models the timeout trap
  task automatic push_instr(input logic [31:0] ins, input int waits, input int trap_len);
    ctl_t c, ca;
    logic [4:0] a;
    logic [1:0] e;
    logic s, d;
    int cls;
    cls = classify(ins, a, e, s, d);
    c = base(3'd0); c.irwr = 1'b1;
    push(c, 1'b1, ins);
    push(base(3'd1), 1'b1, ins);
    if (cls == 7) begin
      exp_ill = 1'b1;
      repeat (trap_len) push(base(3'd7), 1'b1, ins);
      return;
    end
    ca = base(3'd2); ca.aluctr = a; ca.extop = e; ca.alusrc = s;
    c = ca;
    if (cls >= 3) begin
      c.pcwr = 1'b1; c.branch = (cls == 3); c.jump = (cls >= 4); c.regwr = (cls == 5);
      push(c, 1'b1, ins);
      exp_ret++;
      return;
    end
    push(c, 1'b1, ins);
    if (cls == 1 || cls == 2) begin
      c = ca; c.st = 3'd3; c.memwr = (cls == 2);
      for (int i = 0; i < waits && i < TMO; i++) push(c, 1'b0, ins);
      if (waits >= TMO) begin
        exp_berr = 1'b1;
        repeat (trap_len) push(base(3'd7), 1'b0, ins);
        return;
      end
      if (cls == 2) begin
        c.pcwr = 1'b1;
        push(c, 1'b1, ins);
        exp_ret++;
        return;
      end
      push(c, 1'b1, ins);
    end
    c = ca; c.st = 3'd4; c.regwr = 1'b1; c.pcwr = 1'b1; c.regdst = d; c.memtoreg = (cls == 1);
    push(c, 1'b1, ins);
    exp_ret++;
  endtask

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] x);
    n_tests++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  // Entered and left at posedge+1; outputs sampled at the falling edge
  task automatic run_queue();
    exp_t x;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      instruction = x.ins;
      mem_rdy     = x.rdy;
      @(negedge clk);
      n_tests++;
      assert (obs === x.ctl) else begin
        n_fail++;
        $error("FAIL ctl cyc=%0d observed=%h expected=%h", cyc, obs, x.ctl);
      end
      n_tests++;
      assert (retired === x.ret) else begin
        n_fail++;
        $error("FAIL retired cyc=%0d observed=%0d expected=%0d", cyc, retired, x.ret);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    check("rst_async", {32'd0, obs}, {32'd0, base(3'd0)});
    check("rst_retired", {32'd0, retired}, 64'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    exp_ret  = '0;
    exp_ill  = 1'b0;
    exp_berr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_rdy = 1'b0; zero = 1'b0; instruction = 32'h0;
    exp_ret = '0; exp_ill = 1'b0; exp_berr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", {32'd0, obs}, {32'd0, base(3'd0)});
    check("reset_retired", {32'd0, retired}, 64'd0);
    reset = 1'b0;

    push_instr(32'h00221821, 0, 0);            // addu
    run_queue();

    zero = 1'b1;
    push_instr(32'h8C040008, 2, 0);            // lw, 2 wait cycles
    push_instr(32'h10220003, 0, 0);            // beq
    push_instr(32'h14220003, 0, 0);            // bne
    push_instr(32'h0C400100, 0, 0);            // jal
    push_instr(32'h03E00008, 0, 0);            // jr $31
    push_instr(32'h34220055, 0, 0);            // ori
    push_instr(32'h3C011234, 0, 0);            // lui
    push_instr(32'h24010005, 0, 0);            // addiu
    push_instr(32'h00221823, 0, 0);            // subu
    push_instr(32'h00221824, 0, 0);            // and
    push_instr(32'h00221825, 0, 0);            // or
    push_instr(32'h0022182A, 0, 0);            // slt
    push_instr(32'h00021880, 0, 0);            // sll
    push_instr(32'h00021882, 0, 0);            // srl
    push_instr(32'hAC040008, 1, 0);            // sw, 1 wait cycle
    push_instr(32'hAC040008, 0, 0);            // sw, no wait
    push_instr(32'h08000010, 0, 0);            // j
    run_queue();

    push_instr(32'hFC000000, 0, 20);           // opcode 0x3F
    run_queue();
    reset_pulse();

    push_instr(32'h0000003F, 0, 3);            // bad R-type funct
    run_queue();
    reset_pulse();

    push_instr(32'hAC040008, 100, 4);          // sw with mem_rdy stuck low
    run_queue();
    reset_pulse();

    push_instr(32'h00221821, 0, 0);
    run_queue();

    // sw parked in MEM, then reset lands mid-access
    push_instr(32'hAC040008, 100, 0);
    while (sbq.size() > 5) void'(sbq.pop_back());
    exp_berr = 1'b0;
    run_queue();
    check("mem_hold_memwr", {63'd0, MemWr}, 64'd1);
    check("mem_hold_state", {61'd0, state}, 64'd3);
    reset_pulse();

    push_instr(32'h00221821, 0, 0);
    run_queue();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
